message_scroller: RTL and testbench

MESSAGE_SCROLLER -- requirements
Module: message_scroller

---
 rtl/message_scroller_pkg.sv | 35 +++
 rtl/message_scroller_char_decoder.sv | 29 ++
 rtl/message_scroller.sv | 119 +++++++++++
 tb/tb_message_scroller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/message_scroller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : message_scroller_pkg
// Description : Shared constants for the message scroller. Holds the 3-bit
//               character codes, their active-low gfedcba segment patterns
//               and the default message ROM (H,E,L,L,O,blank, then blanks).
// Revision    : 1.0 - initial release
// ============================================================================
package message_scroller_pkg;

    // Character codes; codes 5..7 are unused and decode to blank.
    localparam logic [2:0] c_CH_H     = 3'd0;
    localparam logic [2:0] c_CH_E     = 3'd1;
    localparam logic [2:0] c_CH_L     = 3'd2;
    localparam logic [2:0] c_CH_O     = 3'd3;
    localparam logic [2:0] c_CH_BLANK = 3'd4;

    // Active-low segment patterns, bit order gfedcba.
    localparam logic [6:0] c_SEG_H     = 7'b0001001;
    localparam logic [6:0] c_SEG_E     = 7'b0000110;
    localparam logic [6:0] c_SEG_L     = 7'b1000111;
    localparam logic [6:0] c_SEG_O     = 7'b1000000;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    // Message ROM sized for the largest supported message. Entry 0 is the
    // first character; entries beyond the default text are blank so any
    // MSG_LEN from 2 to 16 reads a well-defined message.
    localparam int c_ROM_DEPTH = 16;
    localparam logic [c_ROM_DEPTH-1:0][2:0] c_MSG_ROM = {
        {10{c_CH_BLANK}},
        c_CH_BLANK, c_CH_O, c_CH_L, c_CH_L, c_CH_E, c_CH_H
    };

endpackage
`default_nettype wire

// File: rtl/message_scroller_char_decoder.sv
`default_nettype none
// ============================================================================
// Module      : char_decoder
// Description : Combinational 3-bit character code to 7-segment decoder.
//               Ports:
//                 i_code [2:0] - character code
//                 o_seg  [6:0] - active-low segments, gfedcba
// Revision    : 1.0 - initial release
// ============================================================================
module char_decoder
    import message_scroller_pkg::*;
(
    input  logic [2:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_SEG_BLANK;
        case (i_code)
            c_CH_H:  o_seg = c_SEG_H;
            c_CH_E:  o_seg = c_SEG_E;
            c_CH_L:  o_seg = c_SEG_L;
            c_CH_O:  o_seg = c_SEG_O;
            default: o_seg = c_SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/message_scroller.sv
`default_nettype none
// ============================================================================
// Module      : message_scroller
// Description : Scrolls a short message across NUM_DIGITS seven-segment
//               digits. Auto-scrolls one position every TICK_DIV cycles
//               while Enable is high; Step rising edges advance manually.
//               Ports:
//                 CLOCK_50 - clock, rising edge
//                 Reset    - synchronous active-high reset
//                 Enable   - 1 runs auto-scroll, 0 pauses
//                 Dir      - 0 scrolls left (offset up), 1 right (down)
//                 Step     - manual advance, acts on its rising edge
//                 HEX      - active-low segments, digit i at [7i+6:7i],
//                            digit 0 rightmost
//                 Offset   - current scroll position
// Revision    : 1.0 - initial release
// ============================================================================
module message_scroller
    import message_scroller_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 6,
    parameter int TICK_DIV   = 50_000_000
)(
    input  logic                       CLOCK_50,
    input  logic                       Reset,
    input  logic                       Enable,
    input  logic                       Dir,
    input  logic                       Step,
    output logic [7*NUM_DIGITS-1:0]    HEX,
    output logic [$clog2(MSG_LEN)-1:0] Offset
);

    localparam int c_OFF_W = $clog2(MSG_LEN);
    localparam int c_DIV_W = $clog2(TICK_DIV);

    localparam logic [c_OFF_W-1:0] c_OFF_MAX = c_OFF_W'(MSG_LEN - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(TICK_DIV - 1);

    localparam logic [0:0] c_ST_PAUSE = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    logic [0:0]              r_state;
    logic [c_DIV_W-1:0]      r_div;
    logic [c_OFF_W-1:0]      r_offset;
    logic                    r_step_q;
    logic [7*NUM_DIGITS-1:0] r_hex;

    logic                    w_tick;
    logic                    w_step_edge;
    logic                    w_advance;
    logic [c_OFF_W-1:0]      w_offset_next;
    logic [7*NUM_DIGITS-1:0] w_hex_next;

    assign w_tick      = (r_state == c_ST_RUN) && (r_div == c_DIV_MAX);
    assign w_step_edge = Step & ~r_step_q;
    // A tick and a Step edge in the same cycle still move the offset once.
    assign w_advance   = w_tick | w_step_edge;

    always_comb begin
        w_offset_next = r_offset;
        if (Dir) begin
            w_offset_next = (r_offset == '0) ? c_OFF_MAX : r_offset - 1'b1;
        end else begin
            w_offset_next = (r_offset == c_OFF_MAX) ? '0 : r_offset + 1'b1;
        end
    end

    // Digit i shows message[(Offset + NUM_DIGITS-1-i) mod MSG_LEN]; the
    // modulo also repeats the message when there are more digits than
    // characters.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [5:0] w_sum;
        logic [3:0] w_pos;
        logic [2:0] w_code;

        assign w_sum  = 6'(r_offset) + 6'(NUM_DIGITS - 1 - gi);
        assign w_pos  = 4'(w_sum % 6'(MSG_LEN));
        assign w_code = c_MSG_ROM[w_pos];

        char_decoder u_char_decoder (
            .i_code (w_code),
            .o_seg  (w_hex_next[7*gi +: 7])
        );
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_state  <= c_ST_PAUSE;
            r_div    <= '0;
            r_offset <= '0;
            r_step_q <= 1'b0;
            r_hex    <= '1;
        end else begin
            r_state  <= Enable ? c_ST_RUN : c_ST_PAUSE;
            r_step_q <= Step;

            // A manual step restarts the auto-scroll interval; a paused
            // divider keeps its count so RUN resumes mid-interval.
            if (w_step_edge) begin
                r_div <= '0;
            end else if (r_state == c_ST_RUN) begin
                r_div <= (r_div == c_DIV_MAX) ? '0 : r_div + 1'b1;
            end

            if (w_advance) begin
                r_offset <= w_offset_next;
            end

            // Decoded from the current offset, so HEX trails Offset by one.
            r_hex <= w_hex_next;
        end
    end

    assign HEX    = r_hex;
    assign Offset = r_offset;

endmodule
`default_nettype wire

// File: tb/tb_message_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_message_scroller
// Description : Self-checking bench for message_scroller with TICK_DIV=4.
//               Directed scenarios followed by randomized stimulus, all
//               compared against a behavioural model of the scroller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_message_scroller;

    localparam int NDIG = 6;
    localparam int LEN  = 6;
    localparam int TDIV = 4;

    localparam logic [6:0] S_H = 7'b0001001;
    localparam logic [6:0] S_E = 7'b0000110;
    localparam logic [6:0] S_L = 7'b1000111;
    localparam logic [6:0] S_O = 7'b1000000;
    localparam logic [6:0] S_B = 7'b1111111;

    localparam logic [41:0] C_ALL_OFF = {42{1'b1}};
    localparam logic [41:0] C_HELLO   = {S_H, S_E, S_L, S_L, S_O, S_B};
    localparam logic [41:0] C_OFF1    = {S_E, S_L, S_L, S_O, S_B, S_H};

    logic        clk = 1'b0;
    logic        rst, en, dir, step;
    logic [41:0] hex;
    logic [2:0]  offset;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    string msg       = "HELLO ";
    int    m_run     = 0;
    int    m_div     = 0;
    int    m_off     = 0;
    int    m_stepq   = 0;
    int    m_hex_off = -1;

    message_scroller #(
        .NUM_DIGITS (NDIG),
        .MSG_LEN    (LEN),
        .TICK_DIV   (TDIV)
    ) dut (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .Enable   (en),
        .Dir      (dir),
        .Step     (step),
        .HEX      (hex),
        .Offset   (offset)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input byte c);
        case (c)
            "H":     return S_H;
            "E":     return S_E;
            "L":     return S_L;
            "O":     return S_O;
            default: return S_B;
        endcase
    endfunction

    function automatic logic [41:0] exp_hex(input int off);
        logic [41:0] h;
        h = C_ALL_OFF;
        if (off >= 0) begin
            for (int i = 0; i < NDIG; i++) begin
                h[7*i +: 7] = seg_of(msg[(off + NDIG - 1 - i) % LEN]);
            end
        end
        return h;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit edge_s, tick_s;
        if (rst) begin
            m_run = 0; m_div = 0; m_off = 0; m_stepq = 0; m_hex_off = -1;
        end else begin
            edge_s    = step && (m_stepq == 0);
            tick_s    = (m_run != 0) && (m_div == TDIV - 1);
            m_hex_off = m_off;
            if (edge_s || tick_s)
                m_off = dir ? (m_off + LEN - 1) % LEN : (m_off + 1) % LEN;
            if (edge_s)     m_div = 0;
            else if (m_run != 0) m_div = (m_div + 1) % TDIV;
            m_run   = en ? 1 : 0;
            m_stepq = step ? 1 : 0;
        end
    endtask

    // One clock: update the model at the edge, compare just after it.
    task automatic step_clk();
        @(posedge clk);
        model_update();
        #1;
        check("offset", 64'(offset), 64'(m_off));
        check("hex", 64'(hex), 64'(exp_hex(m_hex_off)));
    endtask

    initial begin
        int prev;
        bit found;

        rst = 1'b1; en = 1'b0; dir = 1'b0; step = 1'b0;
        repeat (3) step_clk();
        check("reset_hex", 64'(hex), 64'(C_ALL_OFF));
        check("reset_offset", 64'(offset), 64'd0);

        // Run left: ticks every 4 cycles once RUN is entered.
        rst = 1'b0; en = 1'b1;
        step_clk();
        check("hello_after_reset", 64'(hex), 64'(C_HELLO));
        repeat (4) step_clk();
        check("first_tick_offset1", 64'(offset), 64'd1);
        step_clk();
        check("hex_at_offset1", 64'(hex), 64'(C_OFF1));
        repeat (3) step_clk();
        check("second_tick_offset2", 64'(offset), 64'd2);

        // Wrap 5 -> 0 going left, then 0 -> 5 going right.
        repeat (12) step_clk();
        check("reach_offset5", 64'(offset), 64'd5);
        repeat (4) step_clk();
        check("wrap_left_to0", 64'(offset), 64'd0);
        dir = 1'b1;
        repeat (4) step_clk();
        check("wrap_right_to5", 64'(offset), 64'd5);
        step_clk();
        check("hex0_shows_O", 64'(hex[6:0]), 64'(S_O));

        // Pause mid-count for 20 cycles.
        step_clk();
        en = 1'b0;
        step_clk();
        prev = m_off;
        repeat (20) step_clk();
        check("pause_frozen", 64'(offset), 64'(prev));
        en = 1'b1;
        repeat (6) step_clk();

        // Step edge coincident with a tick.
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            if (m_run != 0 && m_div == TDIV - 1) found = 1'b1;
            else step_clk();
        end
        check("wait_tick_align", 64'(found), 64'd1);
        prev = m_off;
        step = 1'b1;
        step_clk();
        step = 1'b0;
        check("coincident_single_adv", 64'(offset), 64'((prev + LEN - 1) % LEN));
        prev = (prev + LEN - 1) % LEN;
        repeat (3) step_clk();
        check("div_cleared_no_adv", 64'(offset), 64'(prev));
        step_clk();
        check("div_cleared_next_tick", 64'(offset), 64'((prev + LEN - 1) % LEN));

        // Step held 10 cycles while paused.
        en = 1'b0;
        repeat (2) step_clk();
        prev = m_off;
        step = 1'b1;
        repeat (10) step_clk();
        step = 1'b0;
        step_clk();
        check("held_step_once", 64'(offset), 64'((prev + LEN - 1) % LEN));

        // Reset at Offset=3 with divider=2.
        en = 1'b1; dir = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (m_run != 0 && m_off == 3 && m_div == 2) found = 1'b1;
            else step_clk();
        end
        check("wait_off3_div2", 64'(found), 64'd1);
        rst = 1'b1;
        repeat (2) step_clk();
        check("mid_reset_hex", 64'(hex), 64'(C_ALL_OFF));
        check("mid_reset_offset", 64'(offset), 64'd0);
        rst = 1'b0;
        step_clk();
        check("release_hello", 64'(hex), 64'(C_HELLO));
        repeat (3) step_clk();
        check("release_no_early_tick", 64'(offset), 64'd0);
        step_clk();
        check("release_full_interval", 64'(offset), 64'd1);

        // Randomized stimulus against the model.
        for (int k = 0; k < 400; k++) begin
            en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            step = ($urandom_range(0, 9) == 0) ? 1'b1
                                               : (step && ($urandom_range(0, 1) == 1));
            rst  = ($urandom_range(0, 99) == 0);
            step_clk();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
